count_cycle_monitor: RTL and testbench
======================================

# count_cycle_monitor

Downstream consumer of the 4-bit mode-controlled counter. Samples the counter's A,B,C,D bits and its Y mode input every clock. Detects each completed pass through the count sequence and reports the cycle count and the measured period in clocks. Flags a stalled counter and any mode change. Its outputs feed the status and self-check logic of the counter datapath.

## Interface
Parameters:
- STALL_LIMIT, 8: consecutive unchanged samples that declare a stall (legal range 2..255)
- CYC_W, 8: width of the completed-cycle counter

Ports:
- clock  in  1  system clock; all state changes on the rising edge
- reset  in  1  asynchronous, active-low; 0 forces every register and output to its reset value immediately
- A,B,C,D  in  1 each  counter bits; A is the MSB; cur = {A,B,C,D}
- Y  in  1  counter mode select, same signal that drives the counter
- clear  in  1  synchronous clear of statistics, active-high
- cycles  out  CYC_W  completed sequence passes since reset/clear; wraps modulo 2^CYC_W
- period  out  8  clocks between the two most recent anchor arrivals; saturates at 255
- period_valid  out  1  period holds a real measurement
- wrap  out  1  one-clock pulse per completed pass
- stall  out  1  level; counter unchanged for STALL_LIMIT samples
- mode_change  out  1  one-clock pulse when Y toggles

## Operation
- Internal registers:
  - anchor[3:0] and prev[3:0]
  - y_q
  - pcnt[7:0], saturating at 255
  - idle[7:0], saturating at 255
  - FSM state: INIT, ARM, RUN, STALL
- Reset values:
  - all outputs 0
  - state = INIT
  - anchor, prev, pcnt and idle = 0
  - y_q = 0
- Priority each edge, highest first: clear, then Y change, then normal FSM.
- clear=1:
  - cycles, period, period_valid, wrap, stall, mode_change, pcnt and idle go to 0
  - state goes to INIT
  - y_q <= Y
- Y != y_q (and no clear), all in the same edge:
  - mode_change <= 1 and y_q <= Y
  - anchor <= cur and prev <= cur
  - pcnt <= 0, idle <= 0
  - period_valid <= 0, stall <= 0
  - state goes to ARM
  - cycles is kept
- INIT: anchor <= cur, prev <= cur, pcnt <= 0, y_q <= Y, then go to ARM.
- ARM (waiting to leave the anchor):
  - pcnt++ every clock
  - if cur != prev, go to RUN
- RUN:
  - pcnt++ every clock
  - anchor arrival is cur == anchor while prev != anchor. On arrival:
    - wrap <= 1 and cycles++
    - period <= sat255(pcnt+1) and period_valid <= 1
    - pcnt <= 0
- Stall tracking, in ARM and RUN:
  - cur == prev increments idle; cur != prev sets idle to 0
  - when idle+1 == STALL_LIMIT: stall <= 1 and state goes to STALL
- STALL:
  - pcnt keeps incrementing (saturating)
  - on cur != prev: stall <= 0, idle <= 0, state goes to RUN
  - the same edge evaluates anchor arrival
- prev <= cur on every edge outside reset.
- wrap and mode_change are 0 on every edge that does not set them.

## Timing
- All outputs are registered.
- A value sampled at edge N shows on the outputs after edge N; latency is 1 clock.
- With a free-running counter of length L, the first anchor arrival is L clocks after capture.
- period = L thereafter; wrap pulses every L clocks.
- Stall asserts after the STALL_LIMIT-th consecutive equal sample.
  - Example: STALL_LIMIT=8 means 8 edges with cur==prev, and stall is high after the 8th.
- Boundary behaviour:
  - A stall ending exactly on the anchor value counts as a wrap, because prev != anchor.
  - A sequence that never returns to the anchor never pulses wrap; period_valid stays 0.
  - cycles wraps 2^CYC_W-1 to 0 without a flag.
  - pcnt saturation holds period at 255.
  - Reset asserted mid-run clears everything asynchronously. The first edge after release behaves as INIT.

## Test plan
- Reset low 10 ns with the counter running, then release:
  - during reset, all outputs are 0
  - on release, anchor is captured on the first rising edge
- Y=0 with the counter stepping 0..15 repeatedly, clock period 10 ns:
  - wrap pulses every 16 clocks
  - period=16, period_valid=1
  - cycles=1, 2, 3 after 16, 32, 48 clocks
- Hold ABCD=0101 for 10 clocks (STALL_LIMIT=8):
  - stall rises after the 8th equal sample
  - stall clears on the first edge after the counter moves
  - wrap is not affected
- Toggle Y 0→1 mid-sequence with cycles=3:
  - mode_change pulses once; period_valid=0; cycles stays 3
  - a new anchor is taken
  - period becomes valid again after one full pass
- Assert clear on the same edge as a Y toggle:
  - clear wins: cycles=0, period_valid=0, mode_change stays 0
- Assert reset low for 3 ns mid-pass with cycles=5:
  - all outputs are 0 immediately, without waiting for a clock edge
  - counting restarts from INIT

Source files
------------

// File: rtl/count_cycle_monitor.sv
// count_cycle_monitor: measures pass count and period of the mode-controlled counter, flags stalls and mode changes
module count_cycle_monitor #(
    parameter int STALL_LIMIT = 8,
    parameter int CYC_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             A,
    input  logic             B,
    input  logic             C,
    input  logic             D,
    input  logic             Y,
    input  logic             clear,
    output logic [CYC_W-1:0] cycles,
    output logic [7:0]       period,
    output logic             period_valid,
    output logic             wrap,
    output logic             stall,
    output logic             mode_change
);
    typedef enum logic [1:0] {INIT, ARM, RUN, STALL} state_t;

    state_t     state;
    logic [3:0] anchor, prev, cur;
    logic       y_q;
    logic [7:0] pcnt, idle, pcnt_inc, idle_inc;
    logic       same, counted, stall_hit;

    assign cur       = {A, B, C, D};
    assign same      = cur == prev;
    assign counted   = (state == RUN || state == STALL) && cur == anchor && prev != anchor;
    assign pcnt_inc  = (pcnt == 8'hff) ? pcnt : pcnt + 8'd1;
    assign idle_inc  = (idle == 8'hff) ? idle : idle + 8'd1;
    assign stall_hit = same && ({1'b0, idle} + 9'd1 == 9'(STALL_LIMIT));

    // clear beats a mode change, which beats the normal tracking FSM
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= INIT;
            anchor       <= 4'd0;
            prev         <= 4'd0;
            y_q          <= 1'b0;
            pcnt         <= 8'd0;
            idle         <= 8'd0;
            cycles       <= '0;
            period       <= 8'd0;
            period_valid <= 1'b0;
            wrap         <= 1'b0;
            stall        <= 1'b0;
            mode_change  <= 1'b0;
        end else begin
            prev        <= cur;
            wrap        <= 1'b0;
            mode_change <= 1'b0;
            if (clear) begin
                cycles       <= '0;
                period       <= 8'd0;
                period_valid <= 1'b0;
                stall        <= 1'b0;
                pcnt         <= 8'd0;
                idle         <= 8'd0;
                state        <= INIT;
                y_q          <= Y;
            end else if (Y != y_q) begin
                mode_change  <= 1'b1;
                y_q          <= Y;
                anchor       <= cur;
                pcnt         <= 8'd0;
                idle         <= 8'd0;
                period_valid <= 1'b0;
                stall        <= 1'b0;
                state        <= ARM;
            end else begin
                case (state)
                    INIT: begin
                        anchor <= cur;
                        pcnt   <= 8'd0;
                        y_q    <= Y;
                        state  <= ARM;
                    end
                    ARM, RUN: begin
                        pcnt <= counted ? 8'd0 : pcnt_inc;
                        idle <= same ? idle_inc : 8'd0;
                        if (stall_hit) begin
                            stall <= 1'b1;
                            state <= STALL;
                        end else if (!same) begin
                            state <= RUN;
                        end
                    end
                    default: begin
                        pcnt <= counted ? 8'd0 : pcnt_inc;
                        if (!same) begin
                            stall <= 1'b0;
                            idle  <= 8'd0;
                            state <= RUN;
                        end
                    end
                endcase
                if (counted) begin
                    wrap         <= 1'b1;
                    cycles       <= cycles + CYC_W'(1);
                    period       <= pcnt_inc;
                    period_valid <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_count_cycle_monitor.sv
// tb_count_cycle_monitor: directed and random stimulus against a behavioural model of the cycle monitor
module tb_count_cycle_monitor;
    localparam int STALL_LIMIT = 8;
    localparam int CYC_W = 8;

    logic             clock, reset, Y, clear;
    logic [3:0]       cnt;
    logic [CYC_W-1:0] cycles;
    logic [7:0]       period;
    logic             period_valid, wrap, stall, mode_change;

    int n_checks = 0;
    int n_fail = 0;

    int         m_cyc, m_per, m_since, m_eq;
    bit         m_pv, m_wr, m_st, m_mc, m_init, m_moved, m_yq;
    logic [3:0] m_anc, m_last;

    count_cycle_monitor #(.STALL_LIMIT(STALL_LIMIT), .CYC_W(CYC_W)) dut (
        .clock(clock), .reset(reset),
        .A(cnt[3]), .B(cnt[2]), .C(cnt[1]), .D(cnt[0]),
        .Y(Y), .clear(clear),
        .cycles(cycles), .period(period), .period_valid(period_valid),
        .wrap(wrap), .stall(stall), .mode_change(mode_change)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_cyc = 0; m_per = 0; m_since = 0; m_eq = 0;
        m_pv = 0; m_wr = 0; m_st = 0; m_mc = 0;
        m_init = 1; m_moved = 0; m_yq = 0;
        m_anc = 4'd0; m_last = 4'd0;
    endtask

    // one rising edge of the monitor, described as pass/period/stall bookkeeping
    task automatic model_edge();
        logic [3:0] c;
        bit arr;
        c = cnt;
        m_wr = 0;
        m_mc = 0;
        if (clear) begin
            m_cyc = 0; m_per = 0; m_pv = 0; m_st = 0;
            m_since = 0; m_eq = 0; m_init = 1; m_yq = Y;
        end else if (Y != m_yq) begin
            m_mc = 1; m_yq = Y; m_anc = c; m_since = 0; m_eq = 0;
            m_pv = 0; m_st = 0; m_init = 0; m_moved = 0;
        end else if (m_init) begin
            m_anc = c; m_since = 0; m_yq = Y; m_init = 0; m_moved = 0;
        end else begin
            arr = m_moved && c == m_anc && m_last != m_anc;
            if (arr) begin
                m_wr = 1;
                m_cyc = (m_cyc + 1) % (1 << CYC_W);
                m_per = (m_since + 1 > 255) ? 255 : m_since + 1;
                m_pv = 1;
                m_since = 0;
            end else begin
                m_since = (m_since < 255) ? m_since + 1 : 255;
            end
            if (c != m_last) begin
                m_moved = 1; m_eq = 0; m_st = 0;
            end else if (!m_st) begin
                m_eq++;
                if (m_eq == STALL_LIMIT) m_st = 1;
            end
        end
        m_last = c;
    endtask

    task automatic cmp_all();
        check("cycles", cycles, m_cyc);
        check("period", period, m_per);
        check("period_valid", period_valid, m_pv);
        check("wrap", wrap, m_wr);
        check("stall", stall, m_st);
        check("mode_change", mode_change, m_mc);
    endtask

    task automatic step();
        @(posedge clock);
        model_edge();
        @(negedge clock);
        cmp_all();
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    initial begin
        model_reset();
        reset = 1'b0; Y = 1'b0; clear = 1'b0; cnt = 4'd3;
        #2 cnt = 4'd4;
        #5 cmp_all();
        check("rst_hold_cycles", cycles, 0);
        #3 reset = 1'b1;
        cnt = 4'd0;
        step();
        for (int i = 1; i <= 48; i++) begin
            cnt = i[3:0];
            step();
            if (i % 16 == 0) begin
                check("pass_cycles", cycles, i / 16);
                check("pass_period", period, 16);
                check("pass_wrap", wrap, 1);
            end
        end
        for (int i = 1; i <= 5; i++) begin
            cnt = i[3:0];
            step();
        end
        for (int k = 1; k <= 10; k++) begin
            step();
            if (k == 7) check("stall_early", stall, 0);
            if (k == 8) check("stall_rise", stall, 1);
        end
        cnt = 4'd6;
        step();
        check("stall_clear", stall, 0);
        check("stall_cycles", cycles, 3);
        cnt = 4'd7;
        Y = 1'b1;
        step();
        check("ytog_mc", mode_change, 1);
        check("ytog_pv", period_valid, 0);
        check("ytog_cycles", cycles, 3);
        for (int k = 1; k <= 16; k++) begin
            cnt = 4'(7 + k);
            step();
        end
        check("ytog_pv_back", period_valid, 1);
        check("ytog_period", period, 16);
        check("ytog_cycles4", cycles, 4);
        Y = 1'b0;
        clear = 1'b1;
        step();
        clear = 1'b0;
        check("clrwin_cycles", cycles, 0);
        check("clrwin_pv", period_valid, 0);
        check("clrwin_mc", mode_change, 0);
        for (int k = 1; k <= 85; k++) begin
            cnt = 4'(7 + k);
            step();
        end
        check("pre_rst_cycles", cycles, 5);
        #1 reset = 1'b0;
        #1 model_reset();
        cmp_all();
        check("async_rst_cycles", cycles, 0);
        check("async_rst_pv", period_valid, 0);
        #2 reset = 1'b1;
        for (int k = 0; k < 40; k++) begin
            cnt = cnt + 4'd1;
            step();
        end
        check("post_rst_cycles", cycles, 2);
        do_clear();
        cnt = 4'd0;
        step();
        for (int i = 1; i <= 15; i++) begin
            cnt = i[3:0];
            step();
        end
        repeat (9) step();
        check("anc_stall", stall, 1);
        cnt = 4'd0;
        step();
        check("anc_stall_wrap", wrap, 1);
        check("anc_stall_off", stall, 0);
        check("anc_stall_cyc", cycles, 1);
        do_clear();
        cnt = 4'd0;
        step();
        for (int i = 0; i < 300; i++) begin
            cnt = 4'(1 + i % 15);
            step();
        end
        check("noret_pv", period_valid, 0);
        check("noret_cycles", cycles, 0);
        cnt = 4'd0;
        step();
        check("sat_period", period, 255);
        check("sat_pv", period_valid, 1);
        do_clear();
        cnt = 4'd0;
        step();
        for (int i = 1; i <= 512; i++) begin
            cnt = 4'(i % 2);
            step();
            if (i == 510) check("cyc_max", cycles, 255);
        end
        check("cyc_wrap", cycles, 0);
        for (int i = 0; i < 3000; i++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 60) cnt = cnt + 4'd1;
            else if (r >= 80) cnt = 4'($urandom_range(0, 15));
            Y = ($urandom_range(0, 149) == 0) ? ~Y : Y;
            clear = ($urandom_range(0, 299) == 0);
            step();
            clear = 1'b0;
            if (r >= 97) repeat ($urandom_range(6, 12)) step();
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
